// File: rtl/mmio_store_ctrl.sv
// IO-space write side: TX byte FIFO feeding the UART transmitter, RX pop strobe,
// and the cycle/retired-instruction counters with their store-triggered clear.
module mmio_store_ctrl #(
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s3_stall,
   input  logic             store_en,
   input  logic             load_en,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      store_data,
   input  logic [3:0]       store_mask,
   input  logic             instr_retire,
   output logic [7:0]       uart_tx_data_in,
   output logic             uart_tx_data_in_valid,
   input  logic             uart_tx_data_in_ready,
   output logic             uart_rx_data_out_ready,
   output logic             tx_ready_status,
   output logic             tx_overflow,
   output logic [CNT_W-1:0] cyc_counter,
   output logic [CNT_W-1:0] instr_counter
);

   localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam logic [PW:0] DepthCnt = (PW+1)'(TX_DEPTH);

   logic [7:0]       mem_q [TX_DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] instr_q, instr_d;

   logic       act, io;
   logic [7:0] offset;
   logic       tx_wr, cnt_rst, full, empty, push, pop;

   always_comb begin
      act     = !s3_stall;
      io      = (mem_addr[31:30] == 2'b10);
      offset  = mem_addr[7:0];
      tx_wr   = act & store_en & io & (offset == 8'h08) & store_mask[0];
      cnt_rst = act & store_en & io & (offset == 8'h18);
      full    = (count_q == DepthCnt);
      empty   = (count_q == '0);
      pop     = !empty & uart_tx_data_in_ready;
      // A full FIFO can still take a byte when the head leaves in the same cycle.
      push    = tx_wr & (!full | pop);
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (tx_wr & full & !pop);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
      if (cnt_rst) begin
         cyc_d   = '0;
         instr_d = '0;
      end else begin
         cyc_d   = cyc_q + CNT_W'(1);
         instr_d = instr_q + CNT_W'(instr_retire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         cyc_q      <= '0;
         instr_q    <= '0;
         for (int i = 0; i < TX_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cyc_q      <= cyc_d;
         instr_q    <= instr_d;
         if (push) begin
            mem_q[wr_ptr_q] <= store_data[7:0];
         end
      end
   end

   assign uart_tx_data_in        = mem_q[rd_ptr_q];
   assign uart_tx_data_in_valid  = !empty;
   assign tx_ready_status        = !full;
   assign tx_overflow            = overflow_q;
   assign uart_rx_data_out_ready = act & load_en & io & (offset == 8'h04);
   assign cyc_counter            = cyc_q;
   assign instr_counter          = instr_q;

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Bench for mmio_store_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the IO write side.
module tb_mmio_store_ctrl;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s3_stall = 1'b0, store_en = 1'b0, load_en = 1'b0;
   logic [31:0] mem_addr = '0, store_data = '0;
   logic [3:0]  store_mask = '0;
   logic        instr_retire = 1'b0, uart_tx_data_in_ready = 1'b0;
   logic [7:0]  uart_tx_data_in;
   logic        uart_tx_data_in_valid, uart_rx_data_out_ready, tx_ready_status, tx_overflow;
   logic [31:0] cyc_counter, instr_counter;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  q_m[$];
   logic        ovf_m = 1'b0;
   logic [31:0] cyc_m = '0, ins_m = '0;

   always #5 clk = ~clk;

   mmio_store_ctrl #(.TX_DEPTH(Depth), .CNT_W(32)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .s3_stall               (s3_stall),
      .store_en               (store_en),
      .load_en                (load_en),
      .mem_addr               (mem_addr),
      .store_data             (store_data),
      .store_mask             (store_mask),
      .instr_retire           (instr_retire),
      .uart_tx_data_in        (uart_tx_data_in),
      .uart_tx_data_in_valid  (uart_tx_data_in_valid),
      .uart_tx_data_in_ready  (uart_tx_data_in_ready),
      .uart_rx_data_out_ready (uart_rx_data_out_ready),
      .tx_ready_status        (tx_ready_status),
      .tx_overflow            (tx_overflow),
      .cyc_counter            (cyc_counter),
      .instr_counter          (instr_counter)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Called at a falling edge: apply inputs, check outputs, advance the model by one rising edge.
   task automatic step(input logic st, input logic se, input logic le, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask, input logic ret,
                       input logic rdy);
      logic io, tx_wr, cnt_rst, rx, was_full, popped;
      s3_stall = st; store_en = se; load_en = le; mem_addr = addr;
      store_data = data; store_mask = mask; instr_retire = ret; uart_tx_data_in_ready = rdy;
      #1;
      io      = (addr >= 32'h8000_0000) && (addr < 32'hC000_0000);
      tx_wr   = !st && se && io && (addr % 256 == 8) && mask[0];
      cnt_rst = !st && se && io && (addr % 256 == 24);
      rx      = !st && le && io && (addr % 256 == 4);
      check_eq("tx_valid", uart_tx_data_in_valid, q_m.size() != 0);
      if (q_m.size() != 0) check_eq("tx_data", uart_tx_data_in, q_m[0]);
      check_eq("tx_ready_status", tx_ready_status, q_m.size() != Depth);
      check_eq("tx_overflow", tx_overflow, ovf_m);
      check_eq("rx_ready", uart_rx_data_out_ready, rx);
      check_eq("cyc_counter", cyc_counter, cyc_m);
      check_eq("instr_counter", instr_counter, ins_m);
      was_full = (q_m.size() == Depth);
      popped   = (q_m.size() != 0) && rdy;
      if (popped) void'(q_m.pop_front());
      if (tx_wr) begin
         if (!was_full || popped) q_m.push_back(data[7:0]);
         else ovf_m = 1'b1;
      end
      if (cnt_rst) begin
         cyc_m = 0; ins_m = 0;
      end else begin
         cyc_m = cyc_m + 1; ins_m = ins_m + 32'(ret);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy, input logic ret);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ret, rdy);
   endtask

   task automatic tx_store(input logic [7:0] b, input logic rdy);
      step(1'b0, 1'b1, 1'b0, 32'h8000_0008, {24'hABCDEF, b}, 4'hF, 1'b0, rdy);
   endtask

   // Called at a falling edge; reset is pulled asynchronously mid-cycle.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_valid", uart_tx_data_in_valid, 0);
      check_eq("rst_data", uart_tx_data_in, 0);
      check_eq("rst_tx_ready", tx_ready_status, 1);
      check_eq("rst_overflow", tx_overflow, 0);
      check_eq("rst_cyc", cyc_counter, 0);
      check_eq("rst_instr", instr_counter, 0);
      q_m.delete(); ovf_m = 1'b0; cyc_m = 0; ins_m = 0;
      store_en = 1'b0; load_en = 1'b0; uart_tx_data_in_ready = 1'b0; instr_retire = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [31:0] addrs [8];

   initial begin
      addrs[0] = 32'h8000_0008; addrs[1] = 32'h8000_0004; addrs[2] = 32'h8000_0000;
      addrs[3] = 32'h0000_0008; addrs[4] = 32'hC000_0008; addrs[5] = 32'h8000_0108;
      addrs[6] = 32'h8000_0010; addrs[7] = 32'h4000_0004;

      @(negedge clk);
      @(negedge clk);
      check_eq("init_valid", uart_tx_data_in_valid, 0);
      check_eq("init_tx_ready", tx_ready_status, 1);
      check_eq("init_data", uart_tx_data_in, 0);
      rst_n = 1'b1;

      // Two bytes drain in order with the transmitter always ready.
      tx_store(8'h41, 1'b1);
      tx_store(8'h42, 1'b1);
      repeat (3) idle(1'b1, 1'b0);

      // Fill with transmitter stalled, fifth store drops, then drain.
      for (int i = 0; i < 5; i++) tx_store(8'h10 + 8'(i), 1'b0);
      repeat (5) idle(1'b1, 1'b0);

      // Full FIFO with push and pop together keeps four entries.
      for (int i = 0; i < 4; i++) tx_store(8'h20 + 8'(i), 1'b0);
      tx_store(8'h99, 1'b1);
      idle(1'b0, 1'b0);
      repeat (5) idle(1'b1, 1'b0);

      // Counter clear: retire on six of ten cycles, then store to offset 0x18.
      for (int i = 0; i < 10; i++) idle(1'b0, i < 6);
      step(1'b0, 1'b1, 1'b0, 32'h8000_0018, 32'h0, 4'h0, 1'b1, 1'b0);
      repeat (2) idle(1'b0, 1'b1);
      // Stalled clear store has no effect.
      step(1'b1, 1'b1, 1'b0, 32'h8000_0018, 32'h0, 4'hF, 1'b0, 1'b0);

      // RX pop strobe and stalled/masked-out variants.
      step(1'b0, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h77, 4'b0010, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h78, 4'hF, 1'b0, 1'b1);
      repeat (2) idle(1'b1, 1'b0);

      // Reset with three queued bytes.
      for (int i = 0; i < 3; i++) tx_store(8'h30 + 8'(i), 1'b0);
      do_reset();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         int unsigned r;
         r = $urandom_range(0, 63);
         a = (r == 0) ? 32'h8000_0018 : addrs[$urandom_range(0, 7)];
         step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              a, $urandom, 4'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0);
         if (n == 1500) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no completion, expected completion");
      $fatal(1, "timeout");
   end

endmodule
